// File: rtl/exe_pkg.sv
// ---------------------------------------------------------------------------
// exe_pkg
// Shared definitions for the execute stage:
//   OP_W           width of the ALU operation code
//   OP_ADD..OP_MUL ALU operation codes (14 and 15 are unassigned/illegal)
//   state_t        execute-stage sequencer states (S_IDLE, S_MUL, S_DONE)
// ---------------------------------------------------------------------------
package exe_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_AND  = 4'd1;
    localparam logic [OP_W-1:0] OP_OR   = 4'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd3;
    localparam logic [OP_W-1:0] OP_ADDU = 4'd4;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd5;
    localparam logic [OP_W-1:0] OP_SUBU = 4'd6;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd7;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd8;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd9;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd10;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd11;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd12;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_iter.sv
// ---------------------------------------------------------------------------
// mul_iter
// Iterative unsigned shift-add multiplier producing the low DATA_W bits of
// i_a * i_b. One multiplier bit is consumed per clock, LSB first, so a
// product takes DATA_W clocks after the start pulse.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   i_start      load operands and begin (ignored state is overwritten)
//   i_a, i_b     multiplicand and multiplier
//   o_last       high during the cycle whose edge performs the final iteration
//   o_product    accumulated product (final once the last iteration is done)
// ---------------------------------------------------------------------------
module mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_last,
    output logic [DATA_W-1:0] o_product
);

    // DATA_W-1 always fits in clog2(DATA_W) bits.
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_run;

    logic [DATA_W-1:0] w_addend;

    // Partial product for this iteration: multiplicand gated by the current
    // multiplier LSB.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_addend
            assign w_addend[gi] = r_mcand[gi] & r_mplier[0];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run) begin
            r_acc    <= r_acc + w_addend;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == LAST_CNT) begin
                r_cnt <= '0;
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_last    = r_run && (r_cnt == LAST_CNT);
    assign o_product = r_acc;

endmodule

// File: rtl/exe_stage_pipe.sv
// ---------------------------------------------------------------------------
// exe_stage_pipe
// MIPS execute stage between ID/EX and EX/MEM. Selects destination register
// and ALU operand B, runs single-cycle ALU ops or an iterative multiply,
// computes the branch target, and hands a registered payload to MEM via a
// valid/ready handshake.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (accept = in_valid && in_ready)
//   pc, imm             instruction PC and sign-extended immediate
//   reg_rd, reg_rt      destination candidates, reg_dst selects rd when 1
//   dato_1, dato_2      register read data (A and B candidate)
//   alu_src             1: B = imm, 0: B = dato_2
//   alu_control         operation code (exe_pkg OP_*)
//   out_valid/out_ready downstream handshake
//   out_dest, out_result, out_zero, out_ovf, out_illegal, out_branch  payload
//   busy                multiply in progress (MUL or DONE)
// ---------------------------------------------------------------------------
module exe_stage_pipe
    import exe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int PC_W   = 32,
    parameter int SH_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] imm,
    input  logic [REG_W-1:0]  reg_rd,
    input  logic [REG_W-1:0]  reg_rt,
    input  logic [DATA_W-1:0] dato_1,
    input  logic [DATA_W-1:0] dato_2,
    input  logic              alu_src,
    input  logic [OP_W-1:0]   alu_control,
    input  logic              reg_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_W-1:0]  out_dest,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_illegal,
    output logic [PC_W-1:0]   out_branch,
    output logic              busy
);

    localparam int MSB = DATA_W - 1;

    state_t            r_state;
    logic              r_busy;
    logic              r_out_valid;
    logic [REG_W-1:0]  r_out_dest;
    logic [DATA_W-1:0] r_out_result;
    logic              r_out_zero;
    logic              r_out_ovf;
    logic              r_out_illegal;
    logic [PC_W-1:0]   r_out_branch;
    // dest/branch of an in-flight multiply, captured at accept
    logic [REG_W-1:0]  r_pend_dest;
    logic [PC_W-1:0]   r_pend_branch;

    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [SH_W-1:0]   w_shamt;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_ovf;
    logic              w_alu_illegal;
    logic [REG_W-1:0]  w_dest;
    logic [PC_W-1:0]   w_imm_pc;
    logic [PC_W-1:0]   w_branch;
    logic              w_slot_free;
    logic              w_accept;
    logic              w_is_mul;
    logic              w_mul_start;
    logic              w_mul_last;
    logic [DATA_W-1:0] w_mul_product;

    // ---------------- operand / destination selection ----------------
    assign w_b     = alu_src ? imm : dato_2;
    assign w_dest  = reg_dst ? reg_rd : reg_rt;
    assign w_sum   = dato_1 + w_b;
    assign w_diff  = dato_1 - w_b;
    assign w_shamt = w_b[SH_W-1:0];

    // Immediate brought to PC width: truncated if narrower, sign-extended
    // if the PC is wider than the datapath.
    generate
        if (PC_W <= DATA_W) begin : g_imm_trunc
            assign w_imm_pc = imm[PC_W-1:0];
        end else begin : g_imm_sext
            assign w_imm_pc = {{(PC_W - DATA_W){imm[MSB]}}, imm};
        end
    endgenerate

    // Modulo 2^PC_W; wrap is intended.
    assign w_branch = pc + PC_W'(4) + (w_imm_pc << 2);

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        w_alu_result  = '0;
        w_alu_ovf     = 1'b0;
        w_alu_illegal = 1'b0;
        case (alu_control)
            OP_ADD: begin
                w_alu_result = w_sum;
                // same-sign operands producing an opposite-sign sum
                w_alu_ovf    = (dato_1[MSB] == w_b[MSB]) && (w_sum[MSB] != dato_1[MSB]);
            end
            OP_AND:  w_alu_result = dato_1 & w_b;
            OP_OR:   w_alu_result = dato_1 | w_b;
            OP_NOR:  w_alu_result = ~(dato_1 | w_b);
            OP_ADDU: w_alu_result = w_sum;
            OP_SUB: begin
                w_alu_result = w_diff;
                // differing-sign operands whose difference flips sign vs A
                w_alu_ovf    = (dato_1[MSB] != w_b[MSB]) && (w_diff[MSB] != dato_1[MSB]);
            end
            OP_SUBU: w_alu_result = w_diff;
            OP_SLT:  w_alu_result = {{(DATA_W-1){1'b0}}, ($signed(dato_1) < $signed(w_b))};
            OP_SLTU: w_alu_result = {{(DATA_W-1){1'b0}}, (dato_1 < w_b)};
            OP_SLL:  w_alu_result = dato_1 << w_shamt;
            OP_SRL:  w_alu_result = dato_1 >> w_shamt;
            OP_SRA:  w_alu_result = $signed(dato_1) >>> w_shamt;
            OP_XOR:  w_alu_result = dato_1 ^ w_b;
            OP_MUL:  w_alu_result = '0;    // produced by mul_iter
            default: w_alu_illegal = 1'b1;
        endcase
    end

    // ---------------- handshake ----------------
    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = (r_state == S_IDLE) && w_slot_free;
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = (alu_control == OP_MUL);
    assign w_mul_start = w_accept && w_is_mul;

    mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_a       (dato_1),
        .i_b       (w_b),
        .o_last    (w_mul_last),
        .o_product (w_mul_product)
    );

    // ---------------- sequencer and output register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_dest    <= '0;
            r_out_result  <= '0;
            r_out_zero    <= 1'b0;
            r_out_ovf     <= 1'b0;
            r_out_illegal <= 1'b0;
            r_out_branch  <= '0;
            r_pend_dest   <= '0;
            r_pend_branch <= '0;
        end else begin
            // Consumed payload drops valid unless replaced below.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state       <= S_MUL;
                            r_busy        <= 1'b1;
                            r_pend_dest   <= w_dest;
                            r_pend_branch <= w_branch;
                        end else begin
                            r_out_valid   <= 1'b1;
                            r_out_dest    <= w_dest;
                            r_out_result  <= w_alu_result;
                            r_out_zero    <= (w_alu_result == '0);
                            r_out_ovf     <= w_alu_ovf;
                            r_out_illegal <= w_alu_illegal;
                            r_out_branch  <= w_branch;
                        end
                    end
                end
                S_MUL: begin
                    if (w_mul_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_slot_free) begin
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_out_dest    <= r_pend_dest;
                        r_out_result  <= w_mul_product;
                        r_out_zero    <= (w_mul_product == '0);
                        r_out_ovf     <= 1'b0;
                        r_out_illegal <= 1'b0;
                        r_out_branch  <= r_pend_branch;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_dest    = r_out_dest;
    assign out_result  = r_out_result;
    assign out_zero    = r_out_zero;
    assign out_ovf     = r_out_ovf;
    assign out_illegal = r_out_illegal;
    assign out_branch  = r_out_branch;
    assign busy        = r_busy;

endmodule

// File: tb/tb_exe_stage_pipe.sv
module tb_exe_stage_pipe;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] pc;
    logic [DW-1:0] imm;
    logic [RW-1:0] reg_rd;
    logic [RW-1:0] reg_rt;
    logic [DW-1:0] dato_1;
    logic [DW-1:0] dato_2;
    logic          alu_src;
    logic [3:0]    alu_control;
    logic          reg_dst;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_dest;
    logic [DW-1:0] out_result;
    logic          out_zero;
    logic          out_ovf;
    logic          out_illegal;
    logic [PW-1:0] out_branch;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    exe_stage_pipe #(.DATA_W(DW), .REG_W(RW), .PC_W(PW), .SH_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .imm(imm), .reg_rd(reg_rd), .reg_rt(reg_rt),
        .dato_1(dato_1), .dato_2(dato_2), .alu_src(alu_src),
        .alu_control(alu_control), .reg_dst(reg_dst),
        .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest),
        .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
        .out_illegal(out_illegal), .out_branch(out_branch), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        ill;
    } ref_t;

    // Reference ALU from the opcode table, using wide arithmetic.
    function automatic ref_t ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        ref_t   r;
        longint sa, sb, s;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        r.res = 32'd0; r.ovf = 1'b0; r.ill = 1'b0;
        case (op)
            0:  begin s = sa + sb; r.res = s[31:0]; r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            1:  r.res = a & b;
            2:  r.res = a | b;
            3:  r.res = ~(a | b);
            4:  r.res = a + b;
            5:  begin s = sa - sb; r.res = s[31:0]; r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            6:  r.res = a - b;
            7:  r.res = (sa < sb) ? 32'd1 : 32'd0;
            8:  r.res = (a < b) ? 32'd1 : 32'd0;
            9:  r.res = a << b[4:0];
            10: r.res = a >> b[4:0];
            11: r.res = 32'(sa >>> b[4:0]);
            12: r.res = a ^ b;
            13: begin p = {32'd0, a} * {32'd0, b}; r.res = p[31:0]; end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_branch(input logic [31:0] p, input logic [31:0] im);
        logic [63:0] t;
        t = {32'd0, p} + 64'd4 + {32'd0, im} * 64'd4;
        return t[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic [31:0] im, input logic [4:0] rd,
                         input logic [4:0] rt, input logic dst, input logic [31:0] p);
        alu_control = op[3:0];
        dato_1 = a; dato_2 = b; alu_src = src; imm = im;
        reg_rd = rd; reg_rt = rt; reg_dst = dst; pc = p;
        in_valid = 1'b1;
    endtask

    // One single-cycle op: accepted at the next edge, payload checked after it.
    task automatic single(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                          input logic src, input logic [31:0] im, input logic [4:0] rd,
                          input logic [4:0] rt, input logic dst, input logic [31:0] p);
        ref_t r;
        logic [31:0] bsel;
        bsel = src ? im : b;
        r = ref_alu(op, a, bsel);
        drive(op, a, b, src, im, rd, rt, dst, p);
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        dato_1 = $urandom; dato_2 = $urandom; pc = $urandom; reg_rd = 5'($urandom);
        $display("[TB] %s op=%0d a=%h b=%h -> res=%h ovf=%0d ill=%0d", tag, op, a, bsel, out_result, out_ovf, out_illegal);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_result"}, out_result, r.res);
        chk({tag, "_zero"}, out_zero, (r.res == 32'd0));
        chk({tag, "_ovf"}, out_ovf, r.ovf);
        chk({tag, "_illegal"}, out_illegal, r.ill);
        chk({tag, "_dest"}, out_dest, dst ? rd : rt);
        chk({tag, "_branch"}, out_branch, ref_branch(p, im));
    endtask

    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b, input bit hold);
        int k;
        logic [31:0] exp_res;
        logic [31:0] p;
        p = $urandom;
        exp_res = ref_alu(13, a, b).res;
        out_ready = 1'b1;
        drive(13, a, b, 1'b0, 32'h10, 5'd3, 5'd7, 1'b1, p);
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        dato_1 = $urandom; dato_2 = $urandom;
        if (hold) out_ready = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_in_ready_busy"}, in_ready, 0);
        chk({tag, "_valid_early"}, out_valid, 0);
        k = 0;
        while (!out_valid && k < 100) begin
            step();
            k++;
        end
        $display("[TB] %s mul %0d*%0d -> %0d after %0d cycles", tag, a, b, out_result, k);
        chk({tag, "_latency"}, k, DW + 1);
        chk({tag, "_result"}, out_result, exp_res);
        chk({tag, "_dest"}, out_dest, 3);
        chk({tag, "_branch"}, out_branch, ref_branch(p, 32'h10));
        chk({tag, "_busy_end"}, busy, 0);
        if (hold) begin
            for (int i = 0; i < 4; i++) begin
                step();
                chk({tag, "_hold_valid"}, out_valid, 1);
                chk({tag, "_hold_result"}, out_result, exp_res);
                chk({tag, "_hold_in_ready"}, in_ready, 0);
            end
            out_ready = 1'b1;
            #1;
            chk({tag, "_release_in_ready"}, in_ready, 1);
            step();
            chk({tag, "_drained"}, out_valid, 0);
        end
    endtask

    initial begin
        logic [31:0] items [3];
        int sent, got, k;
        bit mv, exp_rdy, spurious;
        logic [31:0] mres;
        int op;
        logic [31:0] ra, rb;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        pc = '0; imm = '0; reg_rd = '0; reg_rt = '0; dato_1 = '0; dato_2 = '0;
        alu_src = 1'b0; alu_control = '0; reg_dst = 1'b0;
        step(); step();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", out_result, 0);
        chk("rst_branch", out_branch, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        step();

        // directed single-cycle cases
        single("add_ovf", 0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0, 5'd1, 5'd2, 1'b1, 32'h0);
        single("sub_zero", 5, 32'd5, 32'd5, 1'b0, 32'd0, 5'd1, 5'd2, 1'b1, 32'h40);
        single("slt", 7, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 5'd4, 5'd5, 1'b0, 32'h80);
        single("sltu", 8, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 5'd4, 5'd5, 1'b0, 32'h80);
        single("imm_dest", 0, 32'd10, 32'd99, 1'b1, 32'hFFFF_FFFC, 5'd17, 5'd9, 1'b0, 32'h100);
        chk("imm_branch_const", out_branch, 32'hF4);
        single("illegal15", 15, 32'd123, 32'd456, 1'b0, 32'd0, 5'd1, 5'd2, 1'b1, 32'h0);
        single("sub_ovf", 5, 32'h8000_0000, 32'd1, 1'b0, 32'd0, 5'd1, 5'd2, 1'b1, 32'h0);
        single("sra", 11, 32'h8000_00F0, 32'd4, 1'b0, 32'd0, 5'd1, 5'd2, 1'b1, 32'h0);
        single("branch_wrap", 4, 32'd1, 32'd2, 1'b1, 32'h4000_0000, 5'd1, 5'd2, 1'b1, 32'hFFFF_FFF0);

        // random single-cycle ops, back to back
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 15);
            if (op == 13) op = 14;
            ra = $urandom; rb = $urandom;
            if (i % 8 == 0) rb = ra;
            single("rand", op, ra, rb, 1'($urandom), $urandom, 5'($urandom), 5'($urandom), 1'($urandom), $urandom);
        end
        step();

        // multiply timing and hold
        run_mul("mul", 32'd1234, 32'd5678, 1'b0);
        run_mul("mul_hold", 32'd1234, 32'd5678, 1'b1);
        for (int i = 0; i < 3; i++) run_mul("mul_rand", $urandom, $urandom, 1'b0);
        run_mul("mul_zero", 32'd0, $urandom, 1'b0);
        chk("mul_zero_flag", out_zero, 1);
        step();

        // backpressure stream against a one-entry output slot model
        items[0] = 32'd11; items[1] = 32'd22; items[2] = 32'd33;
        sent = 0; got = 0; mv = 0; mres = '0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            out_ready = (c == 1 || c == 3) ? 1'b0 : 1'b1;
            if (sent < 3) drive(0, items[sent], 32'd100, 1'b0, 32'd0, 5'd1, 5'd2, 1'b1, 32'h0);
            else in_valid = 1'b0;
            #1;
            exp_rdy = !mv || out_ready;
            chk("bp_in_ready", in_ready, exp_rdy);
            chk("bp_valid", out_valid, mv);
            if (mv) chk("bp_result", out_result, mres);
            $display("[TB] bp cycle %0d ready=%0d valid=%0d res=%0d", c, out_ready, out_valid, out_result);
            if (mv && out_ready) begin got++; mv = 0; end
            if (in_valid && exp_rdy) begin mres = items[sent] + 32'd100; mv = 1; sent++; end
            step();
        end
        in_valid = 1'b0;
        chk("bp_count", got, 3);
        out_ready = 1'b1;
        step();

        // reset ten cycles into a multiply
        drive(13, 32'd1234, 32'd5678, 1'b0, 32'd0, 5'd3, 5'd7, 1'b1, 32'h200);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("rstmul_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("rstmul_valid", out_valid, 0);
        chk("rstmul_busy", busy, 0);
        chk("rstmul_result", out_result, 0);
        chk("rstmul_dest", out_dest, 0);
        chk("rstmul_branch", out_branch, 0);
        step();
        reset = 1'b0;
        #1;
        chk("rstmul_in_ready", in_ready, 1);
        spurious = 0;
        k = 0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (out_valid || busy) spurious = 1;
            k++;
        end
        $display("[TB] reset mid-mul: spurious=%0d over %0d cycles", spurious, k);
        chk("rstmul_no_output", spurious, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
